// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with a registered read port.
// Grants are combinational; the owner may keep the RAM for up to MAX_BURST accesses while the other side waits.
module mem_arbiter #(
    parameter int SIZE      = 6,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_req,
    input  logic            a_we,
    input  logic [SIZE-1:0] a_addr,
    input  logic [9:0]      a_wdata,
    input  logic            b_req,
    input  logic            b_we,
    input  logic [SIZE-1:0] b_addr,
    input  logic [9:0]      b_wdata,
    output logic            a_gnt,
    output logic            b_gnt,
    output logic            a_rvalid,
    output logic            b_rvalid,
    output logic [9:0]      a_rdata,
    output logic [9:0]      b_rdata,
    output logic            mem_we,
    output logic [SIZE-1:0] mem_addr,
    output logic [9:0]      mem_wdata,
    input  logic [9:0]      mem_rdata
);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam logic       LAST_A  = 1'b0;
    localparam logic       LAST_B  = 1'b1;
    localparam logic [3:0] MAX_CNT = 4'(MAX_BURST);

    state_t     state_q, state_d;
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic       last_q, last_d;
    logic       a_rvalid_q, a_rvalid_d;
    logic       b_rvalid_q, b_rvalid_d;
    logic       grant_a, grant_b;

    function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
        return (cnt >= MAX_CNT) ? MAX_CNT : cnt + 4'd1;
    endfunction

    always_comb begin
        grant_a     = 1'b0;
        grant_b     = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        last_d      = last_q;

        case (state_q)
            IDLE: begin
                if (a_req && (!b_req || last_q == LAST_B)) grant_a = 1'b1;
                else if (b_req)                            grant_b = 1'b1;
            end
            OWN_A: begin
                if (a_req && (!b_req || burst_cnt_q < MAX_CNT)) grant_a = 1'b1;
                else if (b_req)                                 grant_b = 1'b1;
            end
            OWN_B: begin
                if (b_req && (!a_req || burst_cnt_q < MAX_CNT)) grant_b = 1'b1;
                else if (a_req)                                 grant_a = 1'b1;
            end
            default: begin
                grant_a = 1'b0;
                grant_b = 1'b0;
            end
        endcase

        // Staying with the same owner extends the burst; any switch restarts it at 1.
        if (grant_a) begin
            state_d     = OWN_A;
            burst_cnt_d = (state_q == OWN_A) ? sat_inc(burst_cnt_q) : 4'd1;
            last_d      = LAST_A;
        end else if (grant_b) begin
            state_d     = OWN_B;
            burst_cnt_d = (state_q == OWN_B) ? sat_inc(burst_cnt_q) : 4'd1;
            last_d      = LAST_B;
        end else begin
            state_d     = IDLE;
            burst_cnt_d = 4'd0;
        end
    end

    // Grants are masked by reset so nothing reaches the RAM while rst is low.
    assign a_gnt = grant_a & rst;
    assign b_gnt = grant_b & rst;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (a_gnt) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
        end else if (b_gnt) begin
            mem_we    = b_we;
            mem_addr  = b_addr;
            mem_wdata = b_wdata;
        end
    end

    // Read return follows the RAM's one-cycle latency and the previous cycle's owner.
    assign a_rvalid_d = a_gnt & ~a_we;
    assign b_rvalid_d = b_gnt & ~b_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= 4'd0;
            last_q      <= LAST_B;
            a_rvalid_q  <= 1'b0;
            b_rvalid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            last_q      <= last_d;
            a_rvalid_q  <= a_rvalid_d;
            b_rvalid_q  <= b_rvalid_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = mem_rdata;
    assign b_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written multi-cycle sequences.
// A behavioural single-port RAM with registered read sits behind the arbiter; word i starts as 0x100+i.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [5:0] a_addr, b_addr;
    logic [9:0] a_wdata, b_wdata;
    logic       a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [9:0] a_rdata, b_rdata;
    logic       mem_we;
    logic [5:0] mem_addr;
    logic [9:0] mem_wdata;
    logic [9:0] mem_rdata;

    logic       mem_load;
    logic [9:0] mem [64];

    int pass_cnt = 0;
    int total    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.SIZE(6), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .a_gnt(a_gnt), .b_gnt(b_gnt),
        .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
        .a_rdata(a_rdata), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) mem[i] <= 10'h100 + 10'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    typedef struct packed {
        logic       a_req;
        logic       a_we;
        logic [5:0] a_addr;
        logic [9:0] a_wdata;
        logic       b_req;
        logic       b_we;
        logic [5:0] b_addr;
        logic [9:0] b_wdata;
        logic       e_agnt;
        logic       e_bgnt;
        logic       e_mwe;
        logic [5:0] e_maddr;
        logic [9:0] e_mwdata;
        logic       e_arv;
        logic       e_brv;
        logic [9:0] e_rdata;
    } vec_t;

    vec_t tbl [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input logic ar, input logic aw, input logic [5:0] aa, input logic [9:0] ad,
                         input logic br, input logic bw, input logic [5:0] ba, input logic [9:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at posedge+1 of the first cycle with rst high.
    task automatic do_reset();
        next_cycle();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
    endtask

    initial begin
        rst      = 1'b0;
        mem_load = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) next_cycle();
        mem_load = 1'b0;

        @(negedge clk);
        check("reset_gnts", {30'd0, a_gnt, b_gnt}, 32'd0);
        check("reset_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("reset_mem_we", {31'd0, mem_we}, 32'd0);

        //         a_req a_we a_addr a_wdata   b_req b_we b_addr b_wdata  | agnt bgnt mwe maddr mwdata  arv brv rdata
        tbl[0]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 10'h000};
        tbl[1]  = '{1'b1, 1'b0, 6'd3, 10'h055, 1'b0, 1'b0, 6'd0,  10'h000, 1'b1, 1'b0, 1'b0, 6'd3,  10'h055, 1'b0, 1'b0, 10'h000};
        tbl[2]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b1, 1'b1, 6'd17, 10'h2A5, 1'b0, 1'b1, 1'b1, 6'd17, 10'h2A5, 1'b1, 1'b0, 10'h103};
        tbl[3]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b1, 1'b0, 6'd17, 10'h000, 1'b0, 1'b1, 1'b0, 6'd17, 10'h000, 1'b0, 1'b0, 10'h000};
        tbl[4]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b1, 10'h2A5};
        tbl[5]  = '{1'b1, 1'b1, 6'd5, 10'h111, 1'b1, 1'b0, 6'd9,  10'h000, 1'b1, 1'b0, 1'b1, 6'd5,  10'h111, 1'b0, 1'b0, 10'h000};
        tbl[6]  = '{1'b1, 1'b0, 6'd5, 10'h000, 1'b1, 1'b0, 6'd9,  10'h000, 1'b1, 1'b0, 1'b0, 6'd5,  10'h000, 1'b0, 1'b0, 10'h000};
        tbl[7]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b1, 1'b0, 6'd9,  10'h000, 1'b0, 1'b1, 1'b0, 6'd9,  10'h000, 1'b1, 1'b0, 10'h111};
        tbl[8]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b1, 10'h109};
        tbl[9]  = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b1, 1'b0, 6'd0,  10'h000, 1'b0, 1'b1, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 10'h000};
        tbl[10] = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b1, 10'h100};
        tbl[11] = '{1'b1, 1'b0, 6'd1, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b1, 1'b0, 1'b0, 6'd1,  10'h000, 1'b0, 1'b0, 10'h000};
        tbl[12] = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b1, 1'b0, 10'h101};
        tbl[13] = '{1'b1, 1'b0, 6'd2, 10'h000, 1'b1, 1'b0, 6'd4,  10'h000, 1'b0, 1'b1, 1'b0, 6'd4,  10'h000, 1'b0, 1'b0, 10'h000};
        tbl[14] = '{1'b0, 1'b0, 6'd0, 10'h000, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b0, 1'b0, 6'd0,  10'h000, 1'b0, 1'b1, 10'h104};

        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].a_req, tbl[i].a_we, tbl[i].a_addr, tbl[i].a_wdata,
                  tbl[i].b_req, tbl[i].b_we, tbl[i].b_addr, tbl[i].b_wdata);
            @(negedge clk);
            check($sformatf("tbl%0d_gnt", i), {30'd0, a_gnt, b_gnt}, {30'd0, tbl[i].e_agnt, tbl[i].e_bgnt});
            check($sformatf("tbl%0d_membus", i), {15'd0, mem_we, mem_addr, mem_wdata},
                  {15'd0, tbl[i].e_mwe, tbl[i].e_maddr, tbl[i].e_mwdata});
            check($sformatf("tbl%0d_rvalid", i), {30'd0, a_rvalid, b_rvalid}, {30'd0, tbl[i].e_arv, tbl[i].e_brv});
            if (tbl[i].e_arv) check($sformatf("tbl%0d_a_rdata", i), {22'd0, a_rdata}, {22'd0, tbl[i].e_rdata});
            if (tbl[i].e_brv) check($sformatf("tbl%0d_b_rdata", i), {22'd0, b_rdata}, {22'd0, tbl[i].e_rdata});
            next_cycle();
        end

        // Sustained contention: four A grants, four B grants, and so on, with no gap.
        do_reset();
        drive(1, 0, 6'd6, 0, 1, 0, 6'd7, 0);
        begin
            logic own_a, prev_a;
            prev_a = 1'b0;
            for (int k = 0; k < 12; k++) begin
                own_a = ((k / 4) % 2) == 0;
                @(negedge clk);
                check($sformatf("cont%0d_gnt", k), {30'd0, a_gnt, b_gnt}, {30'd0, own_a, ~own_a});
                check($sformatf("cont%0d_addr", k), {26'd0, mem_addr}, own_a ? 32'd6 : 32'd7);
                if (k > 0) begin
                    check($sformatf("cont%0d_rvalid", k), {30'd0, a_rvalid, b_rvalid}, {30'd0, prev_a, ~prev_a});
                    check($sformatf("cont%0d_rdata", k), {22'd0, mem_rdata}, prev_a ? 32'h106 : 32'h107);
                end
                prev_a = own_a;
                next_cycle();
            end
        end

        // Lone requester B keeps the RAM; once A appears B's saturated burst yields at once.
        do_reset();
        drive(0, 0, 0, 0, 1, 0, 6'd8, 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("solo_b%0d_gnt", k), {30'd0, a_gnt, b_gnt}, 32'd1);
            next_cycle();
        end
        a_req = 1'b1;
        @(negedge clk);
        check("solo_b_yield", {30'd0, a_gnt, b_gnt}, 32'd2);
        next_cycle();

        // Owner switch on a read: A's fourth access reads word 3 as B arrives.
        do_reset();
        drive(1, 0, 6'd3, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("sw_a%0d_gnt", k), {30'd0, a_gnt, b_gnt}, 32'd2);
            next_cycle();
        end
        drive(1, 0, 6'd3, 0, 1, 0, 6'd8, 0);
        @(negedge clk);
        check("sw_a3_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        next_cycle();
        @(negedge clk);
        check("sw_b_gnt", {30'd0, a_gnt, b_gnt}, 32'd1);
        check("sw_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd2);
        check("sw_a_rdata", {22'd0, a_rdata}, 32'h103);
        next_cycle();

        // Reset arriving right after an A read grant drops the pending return.
        do_reset();
        drive(1, 0, 6'd3, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rstmid_a_gnt", {30'd0, a_gnt, b_gnt}, 32'd2);
        next_cycle();
        rst = 1'b0;
        drive(1, 0, 6'd3, 0, 1, 0, 6'd4, 0);
        @(negedge clk);
        check("rstmid_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("rstmid_gnts_low", {30'd0, a_gnt, b_gnt}, 32'd0);
        check("rstmid_mem_we", {31'd0, mem_we}, 32'd0);
        next_cycle();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("rstmid_rvalid_after", {30'd0, a_rvalid, b_rvalid}, 32'd0);
        check("rstmid_idle_gnts", {30'd0, a_gnt, b_gnt}, 32'd0);
        next_cycle();
        drive(1, 0, 6'd2, 0, 1, 0, 6'd4, 0);
        @(negedge clk);
        check("rstmid_first_contention", {30'd0, a_gnt, b_gnt}, 32'd2);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter SIZE, default 6, meaning the memory address width in bits.
REQ-002 The module SHALL have parameter MAX_BURST, default 4, meaning the maximum consecutive grants to one owner while the other requester waits; legal range 1..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have ports a_req, b_req, input, 1 bit each: access request from requester A (fetch) or B (data).
REQ-006 The module SHALL have ports a_we, b_we, input, 1 bit each: 1 means write, 0 means read; qualified by req.
REQ-007 The module SHALL have ports a_addr, b_addr, input, SIZE bits each: word address.
REQ-008 The module SHALL have ports a_wdata, b_wdata, input, 10 bits each: write data.
REQ-009 The module SHALL have ports a_gnt, b_gnt, output, 1 bit each: the access is taken at the next rising clk.
REQ-010 The module SHALL have ports a_rvalid, b_rvalid, output, 1 bit each: read data is valid on the matching rdata this cycle.
REQ-011 The module SHALL have ports a_rdata, b_rdata, output, 10 bits each: read data, driven directly from mem_rdata.
REQ-012 The module SHALL have ports mem_we (1 bit), mem_addr (SIZE bits) and mem_wdata (10 bits), all outputs: drive the single-port RAM.
REQ-013 The module SHALL have port mem_rdata, input, 10 bits: RAM registered read output, valid one clk after the address is presented.

Function
REQ-014 The arbiter SHALL use the states IDLE, OWN_A and OWN_B, plus a burst counter burst_cnt and a last-served flag last.
REQ-015 a_gnt and b_gnt SHALL be combinational from the requests and the registered state, SHALL never both be high, and SHALL be low while rst is low.
REQ-016 Transitions out of IDLE SHALL be:
  - a single requester is granted;
  - if both request, the requester that is not last is granted;
  - the next state is OWN_<granted>, with burst_cnt set to 1.
REQ-017 Transitions in OWN_X with X requesting SHALL be:
  - if the other requester is idle, or burst_cnt < MAX_BURST: X is granted and burst_cnt increments, saturating at MAX_BURST;
  - otherwise the other requester is granted, the state becomes OWN_<other>, and burst_cnt is set to 1.
REQ-018 Transitions in OWN_X with X not requesting SHALL be:
  - if the other requester is requesting: it is granted, the state becomes OWN_<other>, and burst_cnt is set to 1;
  - otherwise no grant, the state becomes IDLE, and burst_cnt is set to 0.
REQ-019 last SHALL update to the granted requester at every clk edge on which a grant occurs.
REQ-020 With a grant high, mem_we, mem_addr and mem_wdata SHALL equal the granted requester's we, addr and wdata (combinational mux); with no grant they SHALL be 0, 0 and 0.
REQ-021 A granted read (we=0) SHALL assert the granted side's rvalid for exactly one cycle, on the cycle after the grant; writes SHALL produce no rvalid.
REQ-022 Back-to-back granted reads SHALL give rvalid on consecutive cycles; the rvalid owner SHALL track the grant owner of the previous cycle, even across an owner switch.
REQ-023 A granted write followed by a granted read of the same address in the next cycle SHALL return the newly written data.
REQ-024 Throughput SHALL be one access per clk whenever any request is pending; the arbiter SHALL insert no idle cycle on an owner switch.

Reset
REQ-025 While rst is low, the arbiter SHALL hold:
  - state = IDLE, burst_cnt = 0, last = B (so A wins the first contention);
  - a_rvalid = b_rvalid = 0, gnts = 0, mem_we = 0.
REQ-026 Reset asserted mid-operation SHALL discard any pending read return: no rvalid after rst is released for accesses granted before reset.
REQ-027 The first grant SHALL occur in the first cycle after rst rises in which a request is present.

Verification
REQ-028 Contention: with MAX_BURST=4, a_req and b_req held high from reset release -> grant sequence A,A,A,A,B,B,B,B,A,... with no gap cycles.
REQ-029 Single requester: only b_req high for 10 cycles -> b_gnt high all 10 cycles, and burst_cnt saturates at 4 with no yield.
REQ-030 Write-then-read: B writes 10'h2A5 to address 6'd17, then B reads 17 in the next cycle -> b_rvalid one cycle after the read grant, with b_rdata = 10'h2A5; a_rvalid stays 0.
REQ-031 Owner switch with reads: A reads address 3 while b_req rises and A's burst is exhausted -> a_rvalid next cycle carrying mem[3], while b_gnt is high the same cycle.
REQ-032 Reset mid-read: rst is pulled low in the cycle after an A read grant -> a_rvalid stays 0, and after release the state is IDLE with last=B.
REQ-033 Idle: no requests -> mem_we = 0, mem_addr = 0, and both gnts low; the arbiter returns to IDLE one cycle after the last request drops.
